// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
//   md_op_t     : RV32M funct3 encoding of the eight M-extension ops
//   md_state_t  : sequencing states of the unit
//   is_signed_a : rs1 is treated as a signed operand
//   is_signed_b : rs2 is treated as a signed operand
//   is_div      : op belongs to the divide/remainder group
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    function automatic logic is_signed_a(md_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(md_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(md_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation used to restore the sign of a
// magnitude-domain result.
//   raw_i   : unsigned magnitude result
//   neg_i   : 1 = negate the result
//   fixed_o : corrected result (modulo 2^WIDTH)
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] raw_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] fixed_o
);

    assign fixed_o = neg_i ? (~raw_i + WIDTH'(1)) : raw_i;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiplier and restoring divider, one bit per cycle,
// operating on operand magnitudes with a sign correction at the end.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   Start        : request, accepted only while Ready
//   MdOp         : RV32M funct3 selecting the operation
//   A, B         : rs1 / rs2, sampled at accept
//   Kill         : flush; abandons the current operation without Done
//   Ready        : idle and able to accept
//   Busy         : iterating or applying sign correction
//   Done         : one-cycle pulse, MdOut valid
//   MdOut        : result, held until the next accept
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Start,
    input  logic [2:0]        MdOp,
    input  logic [DWIDTH-1:0] A,
    input  logic [DWIDTH-1:0] B,
    input  logic              Kill,
    output logic              Ready,
    output logic              Busy,
    output logic              Done,
    output logic [DWIDTH-1:0] MdOut
);

    localparam int CNTW = $clog2(DWIDTH) + 1;
    localparam int PW   = 2 * DWIDTH;
    localparam logic [DWIDTH-1:0] MIN_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    md_state_t         state_q,   state_d;
    md_op_t            op_q,      op_d;
    logic [CNTW-1:0]   cnt_q,     cnt_d;
    logic [DWIDTH-1:0] b_q,       b_d;
    logic [PW-1:0]     acc_q,     acc_d;
    logic              neg_lo_q,  neg_lo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [DWIDTH-1:0] mdout_q,   mdout_d;

    // Operand decode at the accept edge
    md_op_t            op_in;
    logic              neg_a, neg_b;
    logic [DWIDTH-1:0] abs_a, abs_b;
    logic              div_by_zero, div_ovf;

    assign op_in       = md_op_t'(MdOp);
    assign neg_a       = is_signed_a(op_in) & A[DWIDTH-1];
    assign neg_b       = is_signed_b(op_in) & B[DWIDTH-1];
    assign abs_a       = neg_a ? (~A + DWIDTH'(1)) : A;
    assign abs_b       = neg_b ? (~B + DWIDTH'(1)) : B;
    assign div_by_zero = is_div(op_in) && (B == '0);
    assign div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                         (A == MIN_NEG) && (B == '1);

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    // The add keeps its carry so the right shift never loses a bit.
    logic [DWIDTH:0]   mul_sum;
    logic [PW-1:0]     mul_next;

    assign mul_sum  = {1'b0, acc_q[PW-1:DWIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[DWIDTH-1:1]};

    // Divide step: acc = {partial remainder, dividend/quotient bits}.
    // The trial subtraction is one bit wider than the operands so that a
    // shifted remainder of 2^DWIDTH or more is still compared correctly.
    logic [DWIDTH:0]   div_diff;
    logic [PW-1:0]     div_next;

    assign div_diff = acc_q[PW-1:DWIDTH-1] - {1'b0, b_q};
    assign div_next = div_diff[DWIDTH]
                    ? {acc_q[PW-2:DWIDTH-1], acc_q[DWIDTH-2:0], 1'b0}
                    : {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1};

    // Sign correction. Negating the full accumulator also negates its low
    // half modulo 2^DWIDTH, so one instance serves product and quotient.
    logic [PW-1:0]     prod_fix;
    logic [DWIDTH-1:0] rem_fix;
    logic [DWIDTH-1:0] result;

    muldiv_signfix #(.WIDTH(PW)) u_fix_lo (
        .raw_i   (acc_q),
        .neg_i   (neg_lo_q),
        .fixed_o (prod_fix)
    );

    muldiv_signfix #(.WIDTH(DWIDTH)) u_fix_rem (
        .raw_i   (acc_q[PW-1:DWIDTH]),
        .neg_i   (neg_rem_q),
        .fixed_o (rem_fix)
    );

    always_comb begin
        case (op_q)
            OP_MUL, OP_DIV, OP_DIVU:       result = prod_fix[DWIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[PW-1:DWIDTH];
            default:                       result = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_lo_d  = neg_lo_q;
        neg_rem_d = neg_rem_q;
        mdout_d   = mdout_q;

        if (Kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        op_d      = op_in;
                        cnt_d     = '0;
                        b_d       = abs_b;
                        acc_d     = {{DWIDTH{1'b0}}, abs_a};
                        neg_lo_d  = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        state_d   = ST_RUN;
                        // Early-out cases preload the accumulator with the
                        // final raw quotient/remainder and skip iteration;
                        // the FIXUP cycle then only selects the result.
                        if (div_by_zero) begin
                            acc_d     = {A, {DWIDTH{1'b1}}};
                            neg_lo_d  = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = ST_FIXUP;
                        end else if (div_ovf) begin
                            acc_d     = {{DWIDTH{1'b0}}, A};
                            neg_lo_d  = 1'b0;
                            neg_rem_d = 1'b0;
                            state_d   = ST_FIXUP;
                        end
                    end
                end
                ST_RUN: begin
                    acc_d = is_div(op_q) ? div_next : mul_next;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(DWIDTH - 1)) begin
                        state_d = ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    mdout_d = result;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt_q     <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_lo_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            mdout_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_lo_q  <= neg_lo_d;
            neg_rem_q <= neg_rem_d;
            mdout_q   <= mdout_d;
        end
    end

    assign Ready = (state_q == ST_IDLE);
    assign Busy  = (state_q == ST_RUN) || (state_q == ST_FIXUP);
    assign Done  = (state_q == ST_DONE);
    assign MdOut = mdout_q;

endmodule
